// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: directions, command bytes, FSM states.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package snake_pkg;

  // Direction encoding as seen by the segment datapath
  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  // UART command bytes
  localparam logic [7:0] CMD_START   = 8'h53;
  localparam logic [7:0] CMD_RESTART = 8'h52;
  localparam logic [7:0] CMD_PAUSE   = 8'h50;
  localparam logic [7:0] CMD_UP      = 8'h41;
  localparam logic [7:0] CMD_DOWN    = 8'h42;
  localparam logic [7:0] CMD_RIGHT   = 8'h43;
  localparam logic [7:0] CMD_LEFT    = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Opposite direction differs only in the low bit within each axis pair
  function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
    return {dir[1], ~dir[0]};
  endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// Small FIFO of pending turn directions with head and tail peek.
// Latency: push visible at head/tail the cycle after it is written; pop is immediate.
// Backpressure: caller must not push when full unless popping in the same cycle.
module snake_turn_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [1:0] push_dir,
  input  logic       pop,
  input  logic       flush,
  output logic       full,
  output logic       empty,
  output logic [1:0] head,
  output logic [1:0] tail
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] tail_idx;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tail_idx = wr_ptr[AW-1:0] - AW'(1);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign tail     = mem[tail_idx];

  // Storage: write the pushed direction at the write index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_RIGHT;
    end else if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= push_dir;
    end
  end

  // Pointers: flush empties the queue, otherwise advance on push/pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: UART command decode, game FSM, turn filter/queue, step pacing, score.
// Latency: command effect visible 2 cycles after rx_valid rise; move_en 1 cycle after the step tick.
// Backpressure: turn_valid/turn_dir hold until turn_ready; queued turns wait for the next step slot.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int STEP_FRAMES  = 1,
  parameter int TURN_Q_DEPTH = 2,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic               turn_ready,
  output logic               turn_valid,
  output logic [1:0]         turn_dir,
  output logic               move_en,
  output logic               snake_clear,
  output logic               playing,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         cur_dir
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

  state_t              state_q;
  state_t              state_d;
  logic                rx_valid_q;
  logic                cmd_vld_q;
  logic [7:0]          cmd_byte_q;
  logic                cmd_start;
  logic                cmd_restart;
  logic                cmd_pause;
  logic                cmd_arrow;
  logic [1:0]          cmd_dir;
  logic [7:0]          step_cnt_q;
  logic                move_q;
  logic                slot_q;
  logic                coll_q;
  logic [SCORE_W-1:0]  score_q;
  logic [1:0]          cur_dir_q;
  logic                in_play;
  logic                in_clear;
  logic                step_hit;
  logic                resume;
  logic                q_full;
  logic                q_empty;
  logic                q_push;
  logic                q_pop;
  logic [1:0]          q_head;
  logic [1:0]          q_tail;
  logic [1:0]          ref_dir;

  // Register rx_valid and capture the byte on its rising edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_valid_q <= 1'b0;
      cmd_vld_q  <= 1'b0;
      cmd_byte_q <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid;
      cmd_vld_q  <= rx_valid && !rx_valid_q;
      if (rx_valid && !rx_valid_q) cmd_byte_q <= rx_data;
    end
  end

  // Decode the captured byte into one command class
  always_comb begin
    cmd_start   = 1'b0;
    cmd_restart = 1'b0;
    cmd_pause   = 1'b0;
    cmd_arrow   = 1'b0;
    cmd_dir     = DIR_RIGHT;
    if (cmd_vld_q) begin
      case (cmd_byte_q)
        CMD_START:   cmd_start   = 1'b1;
        CMD_RESTART: cmd_restart = 1'b1;
        CMD_PAUSE:   cmd_pause   = 1'b1;
        CMD_UP:      begin cmd_arrow = 1'b1; cmd_dir = DIR_UP;    end
        CMD_DOWN:    begin cmd_arrow = 1'b1; cmd_dir = DIR_DOWN;  end
        CMD_RIGHT:   begin cmd_arrow = 1'b1; cmd_dir = DIR_RIGHT; end
        CMD_LEFT:    begin cmd_arrow = 1'b1; cmd_dir = DIR_LEFT;  end
        default:     ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and state-derived status outputs; commands outrank the collision check
  always_comb begin
    state_d     = state_q;
    snake_clear = 1'b0;
    playing     = 1'b0;
    game_over   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start || cmd_restart) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        snake_clear = 1'b1;
        state_d     = ST_PLAY;
      end
      ST_PLAY: begin
        playing = 1'b1;
        if (cmd_restart)              state_d = ST_CLEAR;
        else if (cmd_pause)           state_d = ST_PAUSE;
        else if (coll_q && frame_tick) state_d = ST_OVER;
      end
      ST_PAUSE: begin
        if (cmd_restart)    state_d = ST_CLEAR;
        else if (cmd_pause) state_d = ST_PLAY;
      end
      ST_OVER: begin
        game_over = 1'b1;
        if (cmd_restart || cmd_start) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_play  = (state_q == ST_PLAY);
  assign in_clear = (state_q == ST_CLEAR);
  assign resume   = (state_q == ST_PAUSE) && (state_d == ST_PLAY);
  // A step only fires if the FSM stays in PLAY, so P/R/game-over suppress it
  assign step_hit = in_play && (state_d == ST_PLAY) && frame_tick && (step_cnt_q == STEP_LAST);

  // Frame counter within the current step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_cnt_q <= 8'd0;
    end else if (in_clear) begin
      step_cnt_q <= 8'd0;
    end else if (in_play && frame_tick) begin
      step_cnt_q <= (step_cnt_q == STEP_LAST) ? 8'd0 : step_cnt_q + 8'd1;
    end
  end

  // Step pulse register feeding move_en one cycle after the completing tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         move_q <= 1'b0;
    else if (in_clear) move_q <= 1'b0;
    else               move_q <= step_hit;
  end

  assign move_en = move_q && in_play;

  // Saturating score, one per completed step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           score_q <= '0;
    else if (in_clear)                   score_q <= '0;
    else if (move_en && score_q != '1)   score_q <= score_q + SCORE_W'(1);
  end

  // Turn slot: one issue permitted per step; a new step re-arms it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_q <= 1'b0;
    end else if (in_clear) begin
      slot_q <= 1'b0;
    end else begin
      if (q_pop)   slot_q <= 1'b0;
      if (move_en) slot_q <= 1'b1;
    end
  end

  // Direction last handed to the datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         cur_dir_q <= DIR_RIGHT;
    else if (in_clear) cur_dir_q <= DIR_RIGHT;
    else if (q_pop)    cur_dir_q <= q_head;
  end

  // Sticky collision latch, re-armed by restart or by resuming from pause
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       coll_q <= 1'b0;
    else if (in_clear || resume)     coll_q <= 1'b0;
    else if (in_play && collision)   coll_q <= 1'b1;
  end

  // Filter compares against the newest queued turn, falling back to the current heading
  assign ref_dir    = q_empty ? cur_dir_q : q_tail;
  assign turn_valid = in_play && slot_q && !q_empty;
  assign turn_dir   = turn_valid ? q_head : DIR_RIGHT;
  assign q_pop      = turn_valid && turn_ready;
  assign q_push     = in_play && cmd_arrow
                   && (cmd_dir != ref_dir)
                   && (cmd_dir != opposite_dir(ref_dir))
                   && (!q_full || q_pop);

  assign score   = score_q;
  assign cur_dir = cur_dir_q;

  snake_turn_fifo #(
    .DEPTH (TURN_Q_DEPTH)
  ) u_turn_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (q_push),
    .push_dir (cmd_dir),
    .pop      (q_pop),
    .flush    (in_clear),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head),
    .tail     (q_tail)
  );

endmodule
